pwm_multi_ch: RTL and testbench
===============================

// Module: pwm_multi_ch
// PURPOSE
//  Multi-channel PWM generator; next-generation replacement for the single-channel core.
//  - One shared period counter drives NUM_CH compare channels.
//  - Period is programmable. Edge- or centre-aligned mode.
//  - Period, mode and duty are double-buffered (shadow -> active) so updates are glitch-free.
//  - Sits between the control-register block (load interface) and the pad/driver stage.
// PARAMETERS
//  WIDTH   8  counter / period / duty resolution (bits)
//  NUM_CH  4  number of PWM channels (>=1)
// PORTS
//  clk        in   1             system clock; single clock domain
//  rst_n      in   1             reset, asynchronous, active-low
//  enable     in   1             run counter; low = hold idle
//  mode_in    in   1             0 = edge-aligned, 1 = centre-aligned (shadowed)
//  period_in  in   WIDTH         period P (shadowed)
//  duty_in    in   NUM_CH*WIDTH  channel i duty at [i*WIDTH +: WIDTH] (shadowed)
//  load_req   in   1             1-cycle pulse: capture mode/period/duty into shadow
//  pwm_out    out  NUM_CH        PWM outputs, registered
//  period_end out  1             1-cycle pulse, first cycle of each new period
//  load_ack   out  1             1-cycle pulse when shadow is transferred to active
// BEHAVIOUR
//  Reset (async):
//   - All outputs 0. cnt = 0, dir = up.
//   - Active and shadow registers = 0. Pending flag = 0.
//  Counter, edge mode: cnt = 0..P-1, then wraps to 0. Period = P cycles.
//   - Terminal cycle: cnt == P-1.
//  Counter, centre mode: cnt goes up 0..P-1, then down P-1..0.
//   - Each endpoint is held 2 cycles. Period = 2P cycles.
//   - Terminal cycle: cnt == 0 with dir = down.
//  Compare: raw[i] = (cnt < duty_act[i]), unsigned, full WIDTH.
//   - Edge mode: high time = min(duty, P) cycles.
//   - Centre mode: high time = 2*min(duty, P) cycles, symmetric about the period boundary.
//   - duty == 0 -> constant low. duty >= P -> constant high, no glitch at wrap.
//  P_act == 0: counter held at 0, all raw = 0, period_end never pulses.
//  Output timing: pwm_out <= enable & raw. One-cycle latency from cnt.
//  Shadow load:
//   - On a load_req cycle: shadow <= {mode_in, period_in, duty_in}; pending <= 1.
//   - A later load_req before transfer overwrites the shadow; the last one wins.
//  Transfer at the clock edge ending a terminal cycle, when pending = 1:
//   - active <= shadow; pending <= 0; load_ack <= 1.
//   - Counter restarts at 0, dir = up.
//  Transfer is all-or-nothing: mode, period and all duties switch on the same edge.
//  load_req during a terminal cycle:
//   - Shadow is written on that edge.
//   - The transfer on that edge uses the pre-write shadow.
//   - The new values apply at the next boundary.
//  period_end: asserted the cycle after each terminal cycle (cnt == 0 of the new period).
//  enable low:
//   - Next cycle: cnt = 0, dir = up, pwm_out = 0, period_end = 0.
//   - A pending shadow transfers on the first disabled edge (load_ack pulses).
//  enable rising: counting resumes from cnt = 0 using the active values.
//  Reset mid-operation: all state cleared immediately, including pending loads.
// CONFIGURATION
//  PWM_POLARITY_EN defined:
//   - Adds port polarity_in [NUM_CH-1:0], shadowed and transferred like duty.
//   - pwm_out[i] = (enable & raw[i]) ^ pol_act[i].
//   - Disabled/idle level = pol_act[i].
//   - Reset value of pol_act = 0.
//  PWM_POLARITY_EN undefined: no polarity_in port; outputs active-high as described above.
// TESTING
//  1. Edge mode, P=10, duty0=3, duty1=0, duty2=10, duty3=255, enable=1
//     -> ch0 high 3 of every 10 cycles; ch1 always 0; ch2/ch3 always 1;
//        period_end every 10 cycles.
//  2. Centre mode, P=4, duty0=1, duty1=3
//     -> 8-cycle period; ch0 high 2 cycles straddling the boundary;
//        ch1 high 6 of 8 cycles, symmetric about the boundary.
//  3. Running duty0=3, P=10; load_req with duty0=7 at cnt=4
//     -> rest of the period stays 3-high; next period 7-high;
//        load_ack is a single pulse aligned with period_end.
//  4. load_req with duty0=7 exactly on the cnt=9 terminal cycle
//     -> the following period still uses 3; duty 7 from the period after.
//  5. Two load_req pulses (duty 5, then 6) within one period -> next period uses 6; one load_ack.
//  6. enable low at cnt=5 -> pwm_out=0 next cycle, cnt=0.
//     Then rst_n low mid-period -> all outputs 0 asynchronously; pending load discarded.

Source files
------------

// File: rtl/pwm_multi_ch.sv
// -----------------------------------------------------------------------------
// pwm_multi_ch
//
// Multi-channel PWM generator. A single shared period counter feeds NUM_CH
// compare channels. The period, the alignment mode and the per-channel duties
// are written into a shadow set by load_req. They move into the active set
// only at a period boundary, or while the block is disabled, so the outputs
// never see a partially updated configuration.
//
// Parameters
//   WIDTH        counter / period / duty resolution in bits
//   NUM_CH       number of PWM channels (>= 1)
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   enable       run the counter; low holds the counter idle at 0
//   mode_in      0 = edge-aligned, 1 = centre-aligned (shadowed)
//   period_in    period P (shadowed)
//   duty_in      channel i duty at [i*WIDTH +: WIDTH] (shadowed)
//   polarity_in  per-channel output inversion (shadowed; PWM_POLARITY_EN only)
//   load_req     single-cycle pulse that captures the inputs into the shadow
//   pwm_out      registered PWM outputs
//   period_end   single-cycle pulse on the first cycle of each new period
//   load_ack     single-cycle pulse when the shadow moves into the active set
//
// Build option
//   PWM_POLARITY_EN  adds polarity_in, so pwm_out[i] = (enable & raw[i]) ^ pol[i]
// -----------------------------------------------------------------------------
module pwm_multi_ch #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      mode_in,
    input  logic [WIDTH-1:0]          period_in,
    input  logic [NUM_CH*WIDTH-1:0]   duty_in,
`ifdef PWM_POLARITY_EN
    input  logic [NUM_CH-1:0]         polarity_in,
`endif
    input  logic                      load_req,
    output logic [NUM_CH-1:0]         pwm_out,
    output logic                      period_end,
    output logic                      load_ack
);

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    // Active and shadow configuration.
    logic                      mode_act_reg,   mode_shd_reg;
    logic [WIDTH-1:0]          period_act_reg, period_shd_reg;
    logic [NUM_CH*WIDTH-1:0]   duty_act_reg,   duty_shd_reg;
    logic [NUM_CH-1:0]         pol_act;
    logic                      pending_reg;

    // Shared counter; dir_down_reg is only ever set in centre mode.
    logic [WIDTH-1:0]          cnt_reg,      cnt_next;
    logic                      dir_down_reg, dir_down_next;

    logic                      p_zero;
    logic                      at_top;
    logic                      terminal;
    logic                      transfer;
    logic [NUM_CH-1:0]         raw;

    assign p_zero = (period_act_reg == ZERO);
    assign at_top = (cnt_reg == (period_act_reg - ONE));

    // The last cycle of a period: the top in edge mode, the second cycle at
    // zero (on the way down) in centre mode. A zero period has no boundaries.
    assign terminal = !p_zero &&
                      (mode_act_reg ? (dir_down_reg && (cnt_reg == ZERO)) : at_top);

    // A zero active period leaves the counter idle, so a pending load is taken
    // on the next edge rather than waiting for a boundary that never comes.
    assign transfer = pending_reg && (!enable || terminal || p_zero);

    always_comb begin
        cnt_next      = cnt_reg;
        dir_down_next = dir_down_reg;
        if (!enable || transfer || p_zero) begin
            cnt_next      = ZERO;
            dir_down_next = 1'b0;
        end else if (!mode_act_reg) begin
            cnt_next      = at_top ? ZERO : (cnt_reg + ONE);
            dir_down_next = 1'b0;
        end else if (!dir_down_reg) begin
            // Top of a centre-aligned ramp is held for one extra cycle while
            // the direction flips.
            if (at_top) begin
                dir_down_next = 1'b1;
            end else begin
                cnt_next = cnt_reg + ONE;
            end
        end else begin
            // Likewise at zero: this is the terminal cycle, next is 0/up.
            if (cnt_reg == ZERO) begin
                dir_down_next = 1'b0;
            end else begin
                cnt_next = cnt_reg - ONE;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_cmp
            assign raw[gi] = !p_zero && (cnt_reg < duty_act_reg[gi*WIDTH +: WIDTH]);
        end
    endgenerate

    // Counter, outputs and pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg      <= ZERO;
            dir_down_reg <= 1'b0;
            pwm_out      <= '0;
            period_end   <= 1'b0;
            load_ack     <= 1'b0;
        end else begin
            cnt_reg      <= cnt_next;
            dir_down_reg <= dir_down_next;
            pwm_out      <= ({NUM_CH{enable}} & raw) ^ pol_act;
            period_end   <= enable && terminal;
            load_ack     <= transfer;
        end
    end

    // Shadow / active configuration. A load_req on a transfer edge writes the
    // shadow while the transfer takes the old shadow, and it stays pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_shd_reg   <= 1'b0;
            period_shd_reg <= ZERO;
            duty_shd_reg   <= '0;
            mode_act_reg   <= 1'b0;
            period_act_reg <= ZERO;
            duty_act_reg   <= '0;
            pending_reg    <= 1'b0;
        end else begin
            if (load_req) begin
                mode_shd_reg   <= mode_in;
                period_shd_reg <= period_in;
                duty_shd_reg   <= duty_in;
            end
            if (transfer) begin
                mode_act_reg   <= mode_shd_reg;
                period_act_reg <= period_shd_reg;
                duty_act_reg   <= duty_shd_reg;
            end
            pending_reg <= load_req || (pending_reg && !transfer);
        end
    end

`ifdef PWM_POLARITY_EN
    logic [NUM_CH-1:0] pol_shd_reg;
    logic [NUM_CH-1:0] pol_act_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pol_shd_reg <= '0;
            pol_act_reg <= '0;
        end else begin
            if (load_req) begin
                pol_shd_reg <= polarity_in;
            end
            if (transfer) begin
                pol_act_reg <= pol_shd_reg;
            end
        end
    end

    assign pol_act = pol_act_reg;
`else
    assign pol_act = '0;
`endif

endmodule

// File: tb/tb_pwm_multi_ch.sv
// -----------------------------------------------------------------------------
// tb_pwm_multi_ch
//
// Directed bench for pwm_multi_ch (WIDTH = 8, NUM_CH = 4, default build).
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_pwm_multi_ch;

    localparam int WIDTH  = 8;
    localparam int NUM_CH = 4;

    logic                    clk;
    logic                    rst_n;
    logic                    enable;
    logic                    mode_in;
    logic [WIDTH-1:0]        period_in;
    logic [NUM_CH*WIDTH-1:0] duty_in;
    logic                    load_req;
    logic [NUM_CH-1:0]       pwm_out;
    logic                    period_end;
    logic                    load_ack;

    int n_cmp  = 0;
    int n_fail = 0;

    pwm_multi_ch #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .mode_in    (mode_in),
        .period_in  (period_in),
        .duty_in    (duty_in),
        .load_req   (load_req),
        .pwm_out    (pwm_out),
        .period_end (period_end),
        .load_ack   (load_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Edge mode, P = 10, duties {255, 10, 0, d0}: ch3 and ch2 always high,
    // ch1 always low, ch0 high while the sampled count is below d0.
    // Each step covers one counter cycle c in [first, last].
    task automatic run_edge(input int d0, input int first, input int last, input bit ack_end);
        for (int c = first; c <= last; c++) begin
            step();
            chk($sformatf("edge_pwm_c%0d_d%0d", c, d0), 32'(pwm_out),
                32'h0000_000c | 32'(c < d0));
            chk($sformatf("edge_pe_c%0d", c), 32'(period_end), 32'(c == 9));
            chk($sformatf("edge_ack_c%0d", c), 32'(load_ack), 32'((c == 9) && ack_end));
        end
    endtask

    task automatic set_edge_cfg(input int d0);
        mode_in   = 1'b0;
        period_in = 8'd10;
        duty_in   = {8'd255, 8'd10, 8'd0, 8'(d0)};
    endtask

    // Centre mode, P = 4: counter 0,1,2,3,3,2,1,0 per 8-cycle period.
    logic [3:0] ctr_pwm [8];
    initial begin
        ctr_pwm[0] = 4'b1011; ctr_pwm[1] = 4'b1010;
        ctr_pwm[2] = 4'b1010; ctr_pwm[3] = 4'b1000;
        ctr_pwm[4] = 4'b1000; ctr_pwm[5] = 4'b1010;
        ctr_pwm[6] = 4'b1010; ctr_pwm[7] = 4'b1011;
    end

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b0;
        mode_in   = 1'b0;
        period_in = '0;
        duty_in   = '0;
        load_req  = 1'b0;

        // Reset state.
        step();
        step();
        chk("rst_pwm", 32'(pwm_out), 32'h0);
        chk("rst_pe",  32'(period_end), 32'h0);
        chk("rst_ack", 32'(load_ack), 32'h0);
        rst_n = 1'b1;

        // 1. Edge mode, loaded while disabled, then three full periods.
        set_edge_cfg(3);
        load_req = 1'b1;
        step();
        load_req = 1'b0;
        chk("t1_ack_early", 32'(load_ack), 32'h0);
        step();
        chk("t1_ack", 32'(load_ack), 32'h1);
        chk("t1_pwm_idle", 32'(pwm_out), 32'h0);
        enable = 1'b1;
        run_edge(3, 0, 9, 1'b0);
        run_edge(3, 0, 9, 1'b0);
        run_edge(3, 0, 9, 1'b0);

        // 3. Mid-period load of duty 7 at cnt = 4.
        run_edge(3, 0, 3, 1'b0);
        set_edge_cfg(7);
        load_req = 1'b1;
        run_edge(3, 4, 4, 1'b0);
        load_req = 1'b0;
        run_edge(3, 5, 9, 1'b1);
        run_edge(7, 0, 9, 1'b0);

        // 4. Load duty 3 exactly on the terminal cycle: one more period of 7.
        run_edge(7, 0, 8, 1'b0);
        set_edge_cfg(3);
        load_req = 1'b1;
        run_edge(7, 9, 9, 1'b0);
        load_req = 1'b0;
        run_edge(7, 0, 9, 1'b1);
        run_edge(3, 0, 9, 1'b0);

        // 5. Two loads in one period (5 then 6): last wins, single ack.
        run_edge(3, 0, 1, 1'b0);
        set_edge_cfg(5);
        load_req = 1'b1;
        run_edge(3, 2, 2, 1'b0);
        load_req = 1'b0;
        run_edge(3, 3, 4, 1'b0);
        set_edge_cfg(6);
        load_req = 1'b1;
        run_edge(3, 5, 5, 1'b0);
        load_req = 1'b0;
        run_edge(3, 6, 9, 1'b1);
        run_edge(6, 0, 9, 1'b0);

        // 6. Disable at cnt = 5, resume from 0, then async reset with a pending load.
        run_edge(6, 0, 4, 1'b0);
        enable = 1'b0;
        step();
        chk("t6_dis_pwm", 32'(pwm_out), 32'h0);
        chk("t6_dis_pe",  32'(period_end), 32'h0);
        chk("t6_dis_ack", 32'(load_ack), 32'h0);
        enable = 1'b1;
        run_edge(6, 0, 2, 1'b0);
        set_edge_cfg(2);
        load_req = 1'b1;
        run_edge(6, 3, 3, 1'b0);
        load_req = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_arst_pwm", 32'(pwm_out), 32'h0);
        chk("t6_arst_pe",  32'(period_end), 32'h0);
        chk("t6_arst_ack", 32'(load_ack), 32'h0);
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("t6_post_pwm_%0d", k), 32'(pwm_out), 32'h0);
            chk($sformatf("t6_post_pe_%0d", k),  32'(period_end), 32'h0);
            chk($sformatf("t6_post_ack_%0d", k), 32'(load_ack), 32'h0);
        end

        // 2. Centre mode, P = 4, duties {4, 0, 3, 1}.
        enable    = 1'b0;
        mode_in   = 1'b1;
        period_in = 8'd4;
        duty_in   = {8'd4, 8'd0, 8'd3, 8'd1};
        load_req  = 1'b1;
        step();
        load_req = 1'b0;
        step();
        chk("t2_ack", 32'(load_ack), 32'h1);
        enable = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step();
            chk($sformatf("ctr_pwm_%0d", k), 32'(pwm_out), 32'(ctr_pwm[k % 8]));
            chk($sformatf("ctr_pe_%0d", k), 32'(period_end), 32'((k % 8) == 7));
            chk($sformatf("ctr_ack_%0d", k), 32'(load_ack), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
